spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Shares one SPI master byte engine among NUM_REQ requesters, one slave per requester.
//  Round-robin arbitration; drives active-low slave selects with programmable setup/hold.
//  Sequences one byte transfer per grant: start, done, rx byte returned to the winner.
//  Sits between client logic and the SPI master; only this block drives ss_n and m_start.
// PARAMETERS
//  NUM_REQ   2    requesters/slaves (2..8); requester i owns ss_n[i]
//  DATA_W    8    bits per transfer
//  CS_SETUP  2    clk cycles ss_n low before m_start (>=1)
//  CS_HOLD   2    clk cycles ss_n held low after m_done (>=1)
//  TIMEOUT   255  clk cycles in WAIT before abort (used only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  rst        in   1                 synchronous, active-low reset
//  req        in   NUM_REQ           level request; held high until matching done
//  req_data   in   NUM_REQ*DATA_W    tx byte of requester i at [i*DATA_W +: DATA_W]
//  gnt        out  NUM_REQ           one-hot grant, high from SETUP through HOLD
//  done       out  NUM_REQ           one-cycle completion pulse to the winner
//  rx_data    out  DATA_W            byte received; valid when any done bit is high
//  err        out  1                 high with done on timeout abort
//  busy       out  1                 high in any state except IDLE
//  m_start    out  1                 one-cycle start pulse to SPI master
//  m_tx_data  out  DATA_W            tx byte, stable from SETUP to end of HOLD
//  m_done     in   1                 one-cycle pulse: master finished the byte
//  m_rx_data  in   DATA_W            master rx byte, valid with m_done
//  ss_n       out  NUM_REQ           active-low slave selects, at most one low
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE, rr_ptr=0, ss_n=all 1, gnt=0, done=0, m_start=0,
//   busy=0, err=0, rx_data=0, m_tx_data=0. Reset mid-transfer aborts: no done, ss_n released.
//  FSM: IDLE -> SETUP -> START -> WAIT -> HOLD -> IDLE. All outputs registered.
//  IDLE: if any req, winner = first set bit at or after rr_ptr (wrap NUM_REQ-1 -> 0);
//   latch winner index and req_data slice; next cycle SETUP.
//  SETUP: ss_n[w]=0, gnt[w]=1; stays CS_SETUP cycles, then START.
//  START: m_start=1 for exactly one cycle; then WAIT.
//  WAIT: on m_done, capture m_rx_data into rx_data; next HOLD. m_done outside WAIT ignored.
//  HOLD: CS_HOLD cycles; on the last, done[w]=1 for one cycle, ss_n all 1, gnt=0,
//   rr_ptr=(w+1) mod NUM_REQ, state IDLE.
//  Latency: req high in IDLE -> m_start after CS_SETUP+1 cycles; m_done -> done CS_HOLD+1.
//  IDLE lasts >=1 cycle between transfers: ss_n high at least one cycle between slaves.
//  req dropped after grant: transfer completes; done still pulses. req_data sampled once.
//  Simultaneous requests: rr_ptr order only; a requester holding req waits <=NUM_REQ-1 grants.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined: 8-bit-min counter runs in WAIT; reaching TIMEOUT without
//   m_done -> rx_data=0, err=1, go HOLD; done and err pulse together on exit; m_done
//   in the same cycle as timeout wins (normal completion, err=0).
//  Undefined: WAIT is unbounded, no counter, err tied 0.
// STRUCTURE
//  spi_arb_pkg: state encodings (IDLE..HOLD), counter width localparams, idx width clog2.
//  Sub-module spi_rr_pick: combinational round-robin picker (req, rr_ptr -> one-hot, index).
//  Top holds FSM, counters, latches, output registers.
// TESTING
//  Single req[0]=1, req_data=8'hA5, m_done 6 cycles after m_start with m_rx_data=8'h3C
//   -> ss_n=2'b10, m_tx_data=A5, m_start 3 cycles after req, done[0] with rx_data=3C.
//  req=2'b11 held, rr_ptr=0 -> grants order 0,1,0,1; ss_n high >=1 cycle between each.
//  req[1] dropped during WAIT -> transfer completes, done[1] pulses, next grant to 0.
//  rst low during WAIT -> next cycle ss_n=2'b11, busy=0, no done; later m_done ignored.
//  TIMEOUT_EN, TIMEOUT=20, m_done never -> done+err after 20 WAIT cycles, rx_data=0.
//  Stray m_done in IDLE/SETUP -> no state change, no done.

Source files
------------

// File: rtl/spi_txn_arbiter_pkg.sv
// spi_txn_arbiter_pkg
//   Shared definitions for the SPI transaction arbiter:
//   - state_e   : arbiter FSM states IDLE..HOLD
//   - bits_for  : width of a counter that must hold 0..v
//   - to_w      : timeout counter width (at least TO_MIN_W bits)
//   - idx_w     : requester index width
package spi_txn_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

   localparam int TO_MIN_W = 8;

   function automatic int bits_for(input int v);
      return (v < 2) ? 1 : $clog2(v + 1);
   endfunction

   function automatic int to_w(input int t);
      return (bits_for(t) < TO_MIN_W) ? TO_MIN_W : bits_for(t);
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if
//   Bundles the client-side request/grant signals and the SPI master byte
//   engine handshake used by spi_txn_arbiter.
//   modport master : arbiter view (drives gnt/done/rx_data/err/busy,
//                    m_start/m_tx_data/ss_n; receives req/req_data,
//                    m_done/m_rx_data)
//   modport slave  : environment view (clients + SPI master), the mirror
//   req_data[i] is the tx byte of requester i.
interface spi_txn_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             done;
   logic [DATA_W-1:0]              rx_data;
   logic                           err;
   logic                           busy;
   logic                           m_start;
   logic [DATA_W-1:0]              m_tx_data;
   logic                           m_done;
   logic [DATA_W-1:0]              m_rx_data;
   logic [NUM_REQ-1:0]             ss_n;

   modport master (
      input  req, req_data, m_done, m_rx_data,
      output gnt, done, rx_data, err, busy, m_start, m_tx_data, ss_n
   );

   modport slave (
      output req, req_data, m_done, m_rx_data,
      input  gnt, done, rx_data, err, busy, m_start, m_tx_data, ss_n
   );
endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// spi_rr_pick
//   Combinational round-robin picker: selects the first set bit of req at or
//   after ptr, wrapping N-1 -> 0.
//   req    in  N      request vector
//   ptr    in  IW     highest-priority index
//   any    out 1      at least one request present
//   idx    out IW     index of winner (0 when none)
//   onehot out N      one-hot winner (0 when none)
module spi_rr_pick
   import spi_txn_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = IW'(j);
         end
      end
      if (any) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master byte engine among NUM_REQ requesters (one slave
//   each). Round-robin grant, active-low slave select with CS_SETUP cycles
//   of setup before m_start and CS_HOLD cycles of hold after m_done, one
//   byte per grant; done pulses to the winner together with rx_data.
//   Ports: clk, rst (synchronous, active low), bus (spi_txn_arbiter_if.master)
//   Optional: SPI_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles; on expiry
//   rx_data=0 and err pulses with done. Undefined: WAIT unbounded, err=0.
//   All outputs come straight from flops loaded with next-state values.
module spi_txn_arbiter
   import spi_txn_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 8,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic clk,
   input  logic rst,
   spi_txn_arbiter_if.master bus
);

   localparam int IDX_W = idx_w(NUM_REQ);
   localparam int PH_W  = bits_for((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
   localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || CS_SETUP < 1 || CS_HOLD < 1 || TIMEOUT < 1)
   begin : g_param_chk
      $error("spi_txn_arbiter: parameter out of range");
   end

   state_e                   state_q, state_d;
   logic [PH_W-1:0]          ph_q, ph_d;
   logic [IDX_W-1:0]         win_q, win_d, ptr_q, ptr_d;
   logic [NUM_REQ-1:0]       sel_q, sel_d;
   logic [DATA_W-1:0]        tx_q, tx_d, rx_q, rx_d;
   logic [NUM_REQ-1:0]       done_d, done_q;
   logic [NUM_REQ-1:0]       ss_n_q, gnt_q;
   logic                     m_start_q, busy_q;

   logic                     pick_any;
   logic [IDX_W-1:0]         pick_idx;
   logic [NUM_REQ-1:0]       pick_oh;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TO_W = to_w(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   logic [TO_W-1:0] to_q, to_d;
   logic            errp_q, errp_d;   // current transfer was aborted
   logic            err_d, err_q;
`endif

   spi_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      win_d   = win_q;
      sel_d   = sel_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      ptr_d   = ptr_q;
      done_d  = '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_d    = to_q;
      errp_d  = errp_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               win_d   = pick_idx;
               sel_d   = pick_oh;
               tx_d    = bus.req_data[pick_idx];   // sampled once per grant
               ph_d    = '0;
               state_d = ST_SETUP;
`ifdef SPI_ARB_TIMEOUT_EN
               errp_d  = 1'b0;
`endif
            end
         end
         ST_SETUP: begin
            if (ph_q == SETUP_LAST) begin
               ph_d    = '0;
               state_d = ST_START;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         ST_WAIT: begin
            // m_done beats a timeout landing in the same cycle
            if (bus.m_done) begin
               rx_d    = bus.m_rx_data;
               ph_d    = '0;
               state_d = ST_HOLD;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (to_q == TO_LAST) begin
               rx_d    = '0;
               errp_d  = 1'b1;
               ph_d    = '0;
               state_d = ST_HOLD;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         ST_HOLD: begin
            if (ph_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               done_d  = sel_q;
               ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
               err_d   = errp_q;
`endif
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ph_q      <= '0;
         win_q     <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         done_q    <= '0;
         ss_n_q    <= '1;
         gnt_q     <= '0;
         m_start_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         win_q     <= win_d;
         sel_q     <= sel_d;
         ptr_q     <= ptr_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         done_q    <= done_d;
         ss_n_q    <= (state_d == ST_IDLE) ? '1 : ~sel_d;
         gnt_q     <= (state_d == ST_IDLE) ? '0 : sel_d;
         m_start_q <= (state_d == ST_START);
         busy_q    <= (state_d != ST_IDLE);
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         to_q   <= '0;
         errp_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         to_q   <= to_d;
         errp_q <= errp_d;
         err_q  <= err_d;
      end
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.rx_data   = rx_q;
   assign bus.busy      = busy_q;
   assign bus.m_start   = m_start_q;
   assign bus.m_tx_data = tx_q;
   assign bus.ss_n      = ss_n_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter
//   Directed bench for spi_txn_arbiter (NUM_REQ=2, CS_SETUP=2, CS_HOLD=2,
//   TIMEOUT=20). A cycle-timeline model predicts every output each cycle;
//   directed scenarios add literal expectations on latency, order and data.
module tb_spi_txn_arbiter;

   localparam int NR  = 2;
   localparam int DW  = 8;
   localparam int CSS = 2;
   localparam int CSH = 2;
   localparam int TO  = 20;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_txn_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

   spi_txn_arbiter #(
      .NUM_REQ(NR), .DATA_W(DW), .CS_SETUP(CSS), .CS_HOLD(CSH), .TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- timeline model ----------------
   // One transfer is described by its grant edge g and completion edge d.
   // SETUP follows edge g, m_start follows edge g+CSS, WAIT starts after
   // edge g+CSS+1, done follows edge d+CSH.
   bit          a_act = 1'b0;
   int          a_g   = 0;
   int          a_d   = -1;
   int          a_w   = 0;
   int          a_ptr = 0;
   logic [DW-1:0] a_tx = '0;
   logic [DW-1:0] a_rx = '0;
   bit          a_err = 1'b0;

   always @(posedge clk) begin
      int n;
      bit idle_prev;
      cyc++;
      n = cyc;
      if (!rst) begin
         a_act = 1'b0; a_d = -1; a_ptr = 0; a_tx = '0; a_rx = '0; a_err = 1'b0;
      end else begin
         idle_prev = !a_act || (a_d >= 0 && n - 1 >= a_d + CSH);
         if (idle_prev) begin
            a_act = 1'b0;
            for (int k = 0; k < NR; k++) begin
               int j;
               j = (a_ptr + k) % NR;
               if (!a_act && bus.req[j]) begin
                  a_act = 1'b1; a_g = n; a_d = -1; a_w = j; a_err = 1'b0;
                  a_tx  = bus.req_data[j];
                  a_ptr = (j + 1) % NR;   // only observable after completion
               end
            end
         end else if (a_d < 0 && n >= a_g + CSS + 2) begin
            if (bus.m_done) begin
               a_d = n; a_rx = bus.m_rx_data; a_err = 1'b0;
            end else if (TO_EN && n == a_g + CSS + 1 + TO) begin
               a_d = n; a_rx = '0; a_err = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [NR-1:0] oh, e_ss, e_gnt, e_done;
         logic e_start, e_busy, e_err;
         oh = '0; e_ss = '1; e_gnt = '0; e_done = '0;
         e_start = 1'b0; e_busy = 1'b0; e_err = 1'b0;
         if (a_act) begin
            oh[a_w] = 1'b1;
            if (a_d < 0 || cyc < a_d + CSH) begin
               e_ss = ~oh; e_gnt = oh; e_busy = 1'b1;
               e_start = (cyc == a_g + CSS);
            end else if (cyc == a_d + CSH) begin
               e_done = oh; e_err = a_err;
            end
         end
         chk("ss_n",      bus.ss_n,      e_ss);
         chk("gnt",       bus.gnt,       e_gnt);
         chk("done",      bus.done,      e_done);
         chk("m_start",   bus.m_start,   e_start);
         chk("busy",      bus.busy,      e_busy);
         chk("err",       bus.err,       e_err);
         chk("rx_data",   bus.rx_data,   a_rx);
         chk("m_tx_data", bus.m_tx_data, a_tx);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0; bus.req = '0; bus.m_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk("rst_ss_n", bus.ss_n, 2'b11);
      chk("rst_gnt", bus.gnt, 2'b00);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_rx", bus.rx_data, 8'h00);
      chk("rst_tx", bus.m_tx_data, 8'h00);
      chk("rst_start", bus.m_start, 1'b0);
      chk_en = 1'b1;
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.m_start === 1'b1) begin s = cyc; break; end
      end
      checks++;
      if (s < 0) begin errors++; $display("FAIL wait_start: got no m_start expected pulse within 60 cycles"); end
   endtask

   task automatic wait_done(output int d, input logic [NR-1:0] drop);
      d = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done !== '0) begin d = cyc; bus.req = bus.req & ~drop; break; end
      end
      checks++;
      if (d < 0) begin errors++; $display("FAIL wait_done: got no done expected pulse within 60 cycles"); end
   endtask

   // m_done pulse dly cycles after the current one
   task automatic respond(input int dly, input logic [DW-1:0] rx);
      repeat (dly) @(posedge clk);
      #1 bus.m_done = 1'b1; bus.m_rx_data = rx;
      @(posedge clk);
      #1 bus.m_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d, t0;
      logic [NR-1:0] order [4];
      bus.req = '0; bus.req_data = '0; bus.m_done = 1'b0; bus.m_rx_data = '0;

      // single requester, basic latencies
      do_reset();
      @(posedge clk); #1;
      bus.req_data[0] = 8'hA5; bus.req = 2'b01; t0 = cyc;
      wait_start(s);
      chk("t1_start_lat", s - t0, 3);
      chk("t1_ss_n", bus.ss_n, 2'b10);
      chk("t1_tx", bus.m_tx_data, 8'hA5);
      respond(6, 8'h3C);
      wait_done(d, 2'b01);
      chk("t1_done", bus.done, 2'b01);
      chk("t1_rx", bus.rx_data, 8'h3C);
      chk("t1_done_lat", d - (s + 6), 3);

      // both requesting continuously from rr_ptr=0
      do_reset();
      @(posedge clk); #1;
      bus.req_data[0] = 8'h11; bus.req_data[1] = 8'h22; bus.req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         wait_start(s);
         order[g] = bus.gnt;
         respond(2 + g, 8'h40 + 8'(g));
         wait_done(d, (g == 3) ? 2'b11 : 2'b00);
         chk("t2_gap_ss_n", bus.ss_n, 2'b11);
         chk("t2_rx", bus.rx_data, 8'h40 + 8'(g));
      end
      chk("t2_order0", order[0], 2'b01);
      chk("t2_order1", order[1], 2'b10);
      chk("t2_order2", order[2], 2'b01);
      chk("t2_order3", order[3], 2'b10);

      // req[1] dropped mid-WAIT, requester 0 takes over
      @(posedge clk); #1;
      bus.req_data[1] = 8'h5A; bus.req = 2'b10;
      wait_start(s);
      chk("t3_gnt1", bus.gnt, 2'b10);
      @(posedge clk); #1;
      bus.req = 2'b01; bus.req_data[0] = 8'hC3; bus.req_data[1] = 8'hFF;
      respond(3, 8'h99);
      wait_done(d, 2'b00);
      chk("t3_done1", bus.done, 2'b10);
      chk("t3_rx", bus.rx_data, 8'h99);
      wait_start(s);
      chk("t3_gnt0", bus.gnt, 2'b01);
      chk("t3_tx0", bus.m_tx_data, 8'hC3);
      respond(2, 8'h77);
      wait_done(d, 2'b01);
      chk("t3_done0", bus.done, 2'b01);

`ifdef SPI_ARB_TIMEOUT_EN
      // no m_done: abort after TO WAIT cycles
      @(posedge clk); #1;
      bus.req_data[0] = 8'h0F; bus.req = 2'b01;
      wait_start(s);
      wait_done(d, 2'b01);
      chk("to_done", bus.done, 2'b01);
      chk("to_err", bus.err, 1'b1);
      chk("to_rx", bus.rx_data, 8'h00);
      chk("to_lat", d - s, 23);
      // m_done in the last WAIT cycle wins over the timeout
      @(posedge clk); #1;
      bus.req = 2'b01;
      wait_start(s);
      respond(20, 8'h66);
      wait_done(d, 2'b01);
      chk("to_edge_err", bus.err, 1'b0);
      chk("to_edge_rx", bus.rx_data, 8'h66);
      chk("to_edge_lat", d - s, 23);
`endif

      // reset during WAIT aborts, later m_done ignored
      @(posedge clk); #1;
      bus.req_data[0] = 8'h3E; bus.req = 2'b01;
      wait_start(s);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; bus.req = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      chk("t4_ss_n", bus.ss_n, 2'b11);
      chk("t4_busy", bus.busy, 1'b0);
      chk("t4_done", bus.done, 2'b00);
      respond(1, 8'hEE);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_no_done", bus.done, 2'b00);
         chk("t4_idle", bus.busy, 1'b0);
      end

      // stray m_done in IDLE and SETUP
      @(posedge clk); #1;
      respond(0, 8'hAA);
      @(negedge clk);
      chk("t6_idle_busy", bus.busy, 1'b0);
      chk("t6_idle_rx", bus.rx_data, 8'h00);
      @(posedge clk); #1;
      bus.req_data[0] = 8'h81; bus.req = 2'b01; t0 = cyc;
      respond(1, 8'hBB);
      wait_start(s);
      chk("t6_start_lat", s - t0, 3);
      chk("t6_rx_hold", bus.rx_data, 8'h00);
      respond(4, 8'h12);
      wait_done(d, 2'b01);
      chk("t6_done", bus.done, 2'b01);
      chk("t6_rx", bus.rx_data, 8'h12);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
